// File: rtl/change_detector_pkg.sv
// Shared constants for the multi-channel change detector.
package change_detector_pkg;

   // Event qualifier selection.
   localparam int unsigned MODE_ANY  = 0;
   localparam int unsigned MODE_UP   = 1;
   localparam int unsigned MODE_DOWN = 2;

   // Glitch-filter state encoding.
   typedef enum logic [0:0] {
      FILT_IDLE    = 1'b0,
      FILT_QUALIFY = 1'b1
   } filt_state_e;

endpackage : change_detector_pkg

// File: rtl/change_detector_ch.sv
// One channel of the change detector: prev register, priming, optional glitch
// filter, direction compare, event pulse and sticky flag.
// Optional filter compiled in with CHANGE_DETECTOR_FILTER_EN.
module change_detector_ch
   import change_detector_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned MODE  = MODE_ANY
`ifdef CHANGE_DETECTOR_FILTER_EN
   ,
   parameter int unsigned FILTER_CYCLES = 4
`endif
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             enable_i,
   input  logic [WIDTH-1:0] signal_i,
   input  logic             clear_i,
   output logic             change_o,
   output logic             sticky_o,
   output logic [WIDTH-1:0] prev_o
);

   logic [WIDTH-1:0] prev_q, prev_d;
   logic             primed_q, primed_d;
   logic             change_q, change_d;
   logic             sticky_q, sticky_d;

   logic             accept_c;
   logic [WIDTH-1:0] accept_val_c;

   // Direction qualifier applied to an accepted value against the old prev.
   function automatic logic mode_hit(input logic [WIDTH-1:0] new_v,
                                     input logic [WIDTH-1:0] old_v);
      if (MODE == MODE_UP)   return new_v > old_v;
      if (MODE == MODE_DOWN) return new_v < old_v;
      return 1'b1;
   endfunction

`ifdef CHANGE_DETECTOR_FILTER_EN
   localparam int unsigned CNT_W = $clog2(FILTER_CYCLES + 1);

   filt_state_e      state_q, state_d;
   logic [WIDTH-1:0] cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Filter next state: a new value must repeat FILTER_CYCLES enabled samples.
   always_comb begin
      state_d      = state_q;
      cand_d       = cand_q;
      cnt_d        = cnt_q;
      accept_c     = 1'b0;
      accept_val_c = cand_q;
      if (enable_i && primed_q) begin
         unique case (state_q)
            FILT_IDLE: begin
               if (signal_i != prev_q) begin
                  if (FILTER_CYCLES == 1) begin
                     accept_c     = 1'b1;
                     accept_val_c = signal_i;
                  end else begin
                     cand_d  = signal_i;
                     cnt_d   = CNT_W'(1);
                     state_d = FILT_QUALIFY;
                  end
               end
            end
            FILT_QUALIFY: begin
               if (signal_i == cand_q) begin
                  if (cnt_q + CNT_W'(1) == CNT_W'(FILTER_CYCLES)) begin
                     accept_c     = 1'b1;
                     accept_val_c = cand_q;
                     cnt_d        = '0;
                     state_d      = FILT_IDLE;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end else if (signal_i == prev_q) begin
                  cnt_d   = '0;
                  state_d = FILT_IDLE;
               end else begin
                  cand_d = signal_i;
                  cnt_d  = CNT_W'(1);
               end
            end
            default: state_d = FILT_IDLE;
         endcase
      end
   end

   // Filter state register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= FILT_IDLE;
         cand_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
      end
   end
`else
   // Unfiltered: any differing enabled sample is accepted at once.
   always_comb begin
      accept_c     = enable_i && primed_q && (signal_i != prev_q);
      accept_val_c = signal_i;
   end
`endif

   // Priming, prev update, pulse generation and sticky flag.
   always_comb begin
      prev_d   = prev_q;
      primed_d = primed_q;
      change_d = 1'b0;
      if (enable_i) begin
         if (!primed_q) begin
            prev_d   = signal_i;
            primed_d = 1'b1;
         end else if (accept_c) begin
            prev_d   = accept_val_c;
            change_d = mode_hit(accept_val_c, prev_q);
         end
      end
      sticky_d = change_d | (sticky_q & ~clear_i);
   end

   // Channel state register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         prev_q   <= '0;
         primed_q <= 1'b0;
         change_q <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         prev_q   <= prev_d;
         primed_q <= primed_d;
         change_q <= change_d;
         sticky_q <= sticky_d;
      end
   end

   assign change_o = change_q;
   assign sticky_o = sticky_q;
   assign prev_o   = prev_q;

endmodule : change_detector_ch

// File: rtl/change_detector.sv
// Multi-channel change detector top: NUM_CH independent channels plus oAny.
// Optional glitch filter compiled in with CHANGE_DETECTOR_FILTER_EN.
module change_detector
   import change_detector_pkg::*;
#(
   parameter int unsigned WIDTH         = 4,
   parameter int unsigned NUM_CH        = 4,
   parameter int unsigned MODE          = MODE_ANY,
   parameter int unsigned FILTER_CYCLES = 4
) (
   input  logic                    iClk,
   input  logic                    iReset,
   input  logic                    iEnable,
   input  logic [NUM_CH*WIDTH-1:0] iSignal,
   input  logic [NUM_CH-1:0]       iClear,
   output logic [NUM_CH-1:0]       oChange,
   output logic [NUM_CH-1:0]       oSticky,
   output logic                    oAny,
   output logic [NUM_CH*WIDTH-1:0] oPrev
);

   // One channel instance per bus slice.
   for (genvar k = 0; k < int'(NUM_CH); k++) begin : g_ch
      change_detector_ch #(
         .WIDTH         (WIDTH),
         .MODE          (MODE)
`ifdef CHANGE_DETECTOR_FILTER_EN
         ,
         .FILTER_CYCLES (FILTER_CYCLES)
`endif
      ) u_ch (
         .clk_i    (iClk),
         .reset_i  (iReset),
         .enable_i (iEnable),
         .signal_i (iSignal[k*WIDTH +: WIDTH]),
         .clear_i  (iClear[k]),
         .change_o (oChange[k]),
         .sticky_o (oSticky[k]),
         .prev_o   (oPrev[k*WIDTH +: WIDTH])
      );
   end

   assign oAny = |oSticky;

endmodule : change_detector

// File: tb/tb_change_detector.sv
// Self-checking bench: three DUTs (MODE ANY/UP/DOWN) share one stimulus stream
// and are compared every cycle against a run-length reference model.
module tb_change_detector;

`ifdef CHANGE_DETECTOR_FILTER_EN
   localparam int FCL = 3;
`else
   localparam int FCL = 1;
`endif

   logic        clk;
   logic        rst;
   logic        en;
   logic [15:0] sig;
   logic [3:0]  clr;

   logic [3:0]  chg [3];
   logic [3:0]  stk [3];
   logic        any [3];
   logic [15:0] prv [3];

   int checks   = 0;
   int failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      change_detector #(
         .WIDTH(4), .NUM_CH(4), .MODE(g), .FILTER_CYCLES(3)
      ) u_dut (
         .iClk(clk), .iReset(rst), .iEnable(en), .iSignal(sig), .iClear(clr),
         .oChange(chg[g]), .oSticky(stk[g]), .oAny(any[g]), .oPrev(prv[g])
      );
   end

   // Reference model: a value is accepted once it has been seen on FCL
   // consecutive enabled samples and differs from the last accepted value.
   logic       m_primed;
   logic [3:0] m_prev    [4];
   logic [3:0] m_run_val [4];
   int         m_run_len [4];
   logic [3:0] m_chg     [3];
   logic [3:0] m_stk     [3];

   function automatic logic hit(input int m, input logic [3:0] nv, input logic [3:0] ov);
      if (m == 1) return nv > ov;
      if (m == 2) return nv < ov;
      return 1'b1;
   endfunction

   task automatic model_update(input logic r, input logic e, input logic [15:0] s,
                               input logic [3:0] c);
      logic [3:0] v;
      for (int m = 0; m < 3; m++) m_chg[m] = 4'h0;
      if (r) begin
         m_primed = 1'b0;
         for (int k = 0; k < 4; k++) begin
            m_prev[k] = 4'h0; m_run_val[k] = 4'h0; m_run_len[k] = 0;
         end
         for (int m = 0; m < 3; m++) m_stk[m] = 4'h0;
         return;
      end
      if (e) begin
         for (int k = 0; k < 4; k++) begin
            v = s[k*4 +: 4];
            if (!m_primed) begin
               m_prev[k] = v; m_run_val[k] = v; m_run_len[k] = 1;
            end else begin
               if (m_run_len[k] > 0 && v == m_run_val[k]) begin
                  if (m_run_len[k] < 1000) m_run_len[k]++;
               end else begin
                  m_run_val[k] = v; m_run_len[k] = 1;
               end
               if (m_run_len[k] == FCL && m_run_val[k] != m_prev[k]) begin
                  for (int m = 0; m < 3; m++)
                     if (hit(m, m_run_val[k], m_prev[k])) m_chg[m][k] = 1'b1;
                  m_prev[k] = m_run_val[k];
               end
            end
         end
         m_primed = 1'b1;
      end
      for (int m = 0; m < 3; m++) m_stk[m] = m_chg[m] | (m_stk[m] & ~c);
   endtask

   function automatic logic [15:0] m_prev_bus();
      logic [15:0] b;
      for (int k = 0; k < 4; k++) b[k*4 +: 4] = m_prev[k];
      return b;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      for (int m = 0; m < 3; m++) begin
         chk($sformatf("model_chg_m%0d", m), 32'(chg[m]), 32'(m_chg[m]));
         chk($sformatf("model_stk_m%0d", m), 32'(stk[m]), 32'(m_stk[m]));
         chk($sformatf("model_any_m%0d", m), 32'(any[m]), 32'(|m_stk[m]));
         chk($sformatf("model_prv_m%0d", m), 32'(prv[m]), 32'(m_prev_bus()));
      end
   endtask

   // Drive at the falling edge, sample on the rising edge, compare at the next fall.
   task automatic step(input logic r, input logic e, input logic [15:0] s,
                       input logic [3:0] c);
      rst = r; en = e; sig = s; clr = c;
      @(posedge clk);
      model_update(r, e, s, c);
      @(negedge clk);
      compare_model();
   endtask

   typedef struct {
      logic        rst;
      logic        en;
      logic [15:0] sig;
      logic [3:0]  clr;
      logic [3:0]  e_chg;
      logic [3:0]  e_stk;
      logic [15:0] e_prv;
   } vec_t;

   vec_t       vecs [12];
   logic [15:0] cur;

   initial begin
      rst = 1'b1; en = 1'b0; sig = 16'h0; clr = 4'h0;
      @(negedge clk);

`ifndef CHANGE_DETECTOR_FILTER_EN
      // Directed table for the MODE=ANY instance: priming, one event, sticky
      // set/clear overlap, clear while disabled, disabled changes.
      vecs[0]  = '{1'b1, 1'b0, 16'h0000, 4'h0, 4'h0, 4'h0, 16'h0000};
      vecs[1]  = '{1'b0, 1'b1, 16'h0003, 4'h0, 4'h0, 4'h0, 16'h0003};
      vecs[2]  = '{1'b0, 1'b1, 16'h0003, 4'h0, 4'h0, 4'h0, 16'h0003};
      vecs[3]  = '{1'b0, 1'b1, 16'h0005, 4'h0, 4'h1, 4'h1, 16'h0005};
      vecs[4]  = '{1'b0, 1'b1, 16'h0005, 4'h0, 4'h0, 4'h1, 16'h0005};
      vecs[5]  = '{1'b0, 1'b1, 16'h0006, 4'h1, 4'h1, 4'h1, 16'h0006};
      vecs[6]  = '{1'b0, 1'b1, 16'h0006, 4'h1, 4'h0, 4'h0, 16'h0006};
      vecs[7]  = '{1'b0, 1'b1, 16'h0106, 4'h0, 4'h4, 4'h4, 16'h0106};
      vecs[8]  = '{1'b0, 1'b0, 16'h0906, 4'h4, 4'h0, 4'h0, 16'h0106};
      vecs[9]  = '{1'b0, 1'b0, 16'h0906, 4'h0, 4'h0, 4'h0, 16'h0106};
      vecs[10] = '{1'b0, 1'b1, 16'h0906, 4'h0, 4'h4, 4'h4, 16'h0906};
      vecs[11] = '{1'b0, 1'b0, 16'h0000, 4'h0, 4'h0, 4'h4, 16'h0906};
      for (int i = 0; i < 12; i++) begin
         step(vecs[i].rst, vecs[i].en, vecs[i].sig, vecs[i].clr);
         chk($sformatf("vec%0d_chg", i), 32'(chg[0]), 32'(vecs[i].e_chg));
         chk($sformatf("vec%0d_stk", i), 32'(stk[0]), 32'(vecs[i].e_stk));
         chk($sformatf("vec%0d_any", i), 32'(any[0]), 32'(|vecs[i].e_stk));
         chk($sformatf("vec%0d_prv", i), 32'(prv[0]), 32'(vecs[i].e_prv));
      end
`else
      // Filter, FILTER_CYCLES=3: short glitch rejected, restart on a new value.
      step(1'b1, 1'b0, 16'h0000, 4'h0);
      step(1'b0, 1'b1, 16'h0000, 4'h0);
      step(1'b0, 1'b1, 16'h7000, 4'h0);
      step(1'b0, 1'b1, 16'h7000, 4'h0);
      step(1'b0, 1'b1, 16'h0000, 4'h0);
      chk("filt_glitch_chg", 32'(chg[0]), 32'h0);
      chk("filt_glitch_prv", 32'(prv[0]), 32'h0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 16'h7000, 4'h0);
         chk($sformatf("filt_hold%0d_chg", i), 32'(chg[0]), (i == 2) ? 32'h8 : 32'h0);
      end
      chk("filt_hold_prv", 32'(prv[0]), 32'h7000);
      step(1'b1, 1'b0, 16'h0000, 4'h0);
      step(1'b0, 1'b1, 16'h0000, 4'h0);
      step(1'b0, 1'b1, 16'h7000, 4'h0);
      step(1'b0, 1'b1, 16'h7000, 4'h0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 16'h2000, 4'h0);
         chk($sformatf("filt_restart%0d_chg", i), 32'(chg[0]), (i == 2) ? 32'h8 : 32'h0);
      end
      chk("filt_restart_prv", 32'(prv[0]), 32'h2000);
`endif

      // Direction modes on ch1: 8 -> 4 -> 6, each value held FCL samples.
      step(1'b1, 1'b0, 16'h0000, 4'h0);
      step(1'b0, 1'b1, 16'h0080, 4'h0);
      for (int i = 0; i < FCL; i++) step(1'b0, 1'b1, 16'h0040, 4'h0);
      chk("up_8to4_chg",   32'(chg[1]), 32'h0);
      chk("up_8to4_prv",   32'(prv[1]), 32'h0040);
      chk("down_8to4_chg", 32'(chg[2]), 32'h2);
      for (int i = 0; i < FCL; i++) step(1'b0, 1'b1, 16'h0060, 4'h0);
      chk("up_4to6_chg",   32'(chg[1]), 32'h2);
      chk("down_4to6_chg", 32'(chg[2]), 32'h0);
      chk("down_4to6_prv", 32'(prv[2]), 32'h0060);

      // Reset mid-pulse / mid-qualification, then re-priming without event.
      step(1'b0, 1'b1, 16'h0065, 4'h0);
      step(1'b1, 1'b1, 16'h0065, 4'h0);
      for (int m = 0; m < 3; m++) begin
         chk($sformatf("rst_chg_m%0d", m), 32'(chg[m]), 32'h0);
         chk($sformatf("rst_stk_m%0d", m), 32'(stk[m]), 32'h0);
         chk($sformatf("rst_any_m%0d", m), 32'(any[m]), 32'h0);
         chk($sformatf("rst_prv_m%0d", m), 32'(prv[m]), 32'h0);
      end
      step(1'b0, 1'b1, 16'h000a, 4'h0);
      chk("reprime_chg", 32'(chg[0]), 32'h0);
      chk("reprime_prv", 32'(prv[0]), 32'h000a);

      // Randomised run against the model.
      cur = 16'h0;
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < 4; k++)
            if ($urandom_range(0, 3) == 0) cur[k*4 +: 4] = 4'($urandom_range(0, 3));
         step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), cur,
              ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_change_detector
